// File: rtl/gcd_result_queue.sv
// Result FIFO behind the GCD core: absorbs unthrottled result pulses and tracks jobs in flight.
// Optional macro GCD_RQ_DROP_STATS_EN adds a saturating 8-bit counter of dropped results on io_drops.
module gcd_result_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_issue,
   input  logic                     io_in_valid,
   input  logic [WIDTH-1:0]         io_in_data,
   output logic                     io_issue_ok,
   output logic                     io_out_valid,
   input  logic                     io_out_ready,
   output logic [WIDTH-1:0]         io_out_data,
   output logic [$clog2(DEPTH):0]   io_count,
   output logic                     io_overflow,
   output logic [7:0]               io_drops
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

   function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + ONE;
   endfunction

   function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
      return (v == '0) ? v : v - ONE;
   endfunction

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    wp_q, wp_d;
   logic [CW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic             overflow_q, overflow_d;
   logic             empty, full, push, pop, drop;
   logic [CW-1:0]    count;
   logic [CW:0]      budget;

   always_comb begin
      empty = (wp_q == rp_q);
      full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
      pop   = !empty && io_out_ready;
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      push  = io_in_valid && (!full || pop);
      drop  = io_in_valid && full && !pop;

      wp_d = push ? wp_q + ONE : wp_q;
      rp_d = pop  ? rp_q + ONE : rp_q;

      inflight_d = inflight_q;
      case ({io_issue, io_in_valid})
         2'b10:   inflight_d = inc_sat(inflight_q);
         2'b01:   inflight_d = dec_sat(inflight_q);
         default: inflight_d = inflight_q;
      endcase

      overflow_d = overflow_q | drop;

      count  = wp_q - rp_q;
      budget = {1'b0, count} + {1'b0, inflight_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         inflight_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q[AW-1:0]] <= io_in_data;
      end
   end

`ifdef GCD_RQ_DROP_STATS_EN
   logic [7:0] drops_q, drops_d;

   always_comb begin
      drops_d = drops_q;
      if (drop && (drops_q != 8'hFF)) begin
         drops_d = drops_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drops_q <= 8'h00;
      end else begin
         drops_q <= drops_d;
      end
   end

   assign io_drops = drops_q;
`else
   assign io_drops = 8'h00;
`endif

   assign io_out_valid = !empty;
   assign io_out_data  = mem_q[rp_q[AW-1:0]];
   assign io_count     = count;
   assign io_overflow  = overflow_q;
   assign io_issue_ok  = (budget < DEPTH_L);

endmodule

// File: tb/tb_gcd_result_queue.sv
// Directed self-checking bench for gcd_result_queue (DEPTH=4, WIDTH=16).
module tb_gcd_result_queue;

   logic        clk;
   logic        reset;
   logic        io_issue;
   logic        io_in_valid;
   logic [15:0] io_in_data;
   logic        io_issue_ok;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [15:0] io_out_data;
   logic [2:0]  io_count;
   logic        io_overflow;
   logic [7:0]  io_drops;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef GCD_RQ_DROP_STATS_EN
   localparam logic [7:0] EXP_DROP1   = 8'd1;
   localparam logic [7:0] EXP_DROP100 = 8'd100;
   localparam logic [7:0] EXP_DROPSAT = 8'hFF;
`else
   localparam logic [7:0] EXP_DROP1   = 8'd0;
   localparam logic [7:0] EXP_DROP100 = 8'd0;
   localparam logic [7:0] EXP_DROPSAT = 8'd0;
`endif

   gcd_result_queue #(.DEPTH(4), .WIDTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_issue     (io_issue),
      .io_in_valid  (io_in_valid),
      .io_in_data   (io_in_data),
      .io_issue_ok  (io_issue_ok),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_data  (io_out_data),
      .io_count     (io_count),
      .io_overflow  (io_overflow),
      .io_drops     (io_drops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      io_issue     = 1'b0;
      io_in_valid  = 1'b0;
      io_in_data   = 16'h0;
      io_out_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", io_out_valid); end
      n_checks++; if (io_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", io_count); end
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", io_overflow); end
      n_checks++; if (io_drops !== 8'h00) begin n_fail++; $display("FAIL reset_drops: got %h expected 00", io_drops); end
      n_checks++; if (io_issue_ok !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ok: got %b expected 1", io_issue_ok); end
   endtask

   task automatic test_order();
      logic [15:0] exp_q [3];
      exp_q[0] = 16'h0003; exp_q[1] = 16'h0005; exp_q[2] = 16'h0007;
      io_out_ready = 1'b0;
      io_in_valid  = 1'b1;
      io_in_data   = 16'h0003;
      tick();
      n_checks++; if (io_out_valid !== 1'b1 || io_out_data !== 16'h0003) begin n_fail++; $display("FAIL order_latency: got v=%b d=%h expected v=1 d=0003", io_out_valid, io_out_data); end
      io_in_data = 16'h0005;
      tick();
      io_in_data = 16'h0007;
      tick();
      io_in_valid = 1'b0;
      n_checks++; if (io_count !== 3'd3) begin n_fail++; $display("FAIL order_count: got %0d expected 3", io_count); end
      io_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (io_out_valid !== 1'b1 || io_out_data !== exp_q[i]) begin n_fail++; $display("FAIL order_data%0d: got v=%b d=%h expected v=1 d=%h", i, io_out_valid, io_out_data, exp_q[i]); end
         tick();
      end
      n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b expected 0", io_out_valid); end
      io_out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      io_out_ready = 1'b0;
      io_in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         io_in_data = 16'(i);
         tick();
      end
      n_checks++; if (io_count !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_count: got %0d expected 4", io_count); end
      n_checks++; if (io_issue_ok !== 1'b0) begin n_fail++; $display("FAIL ovf_issue_ok_full: got %b expected 0", io_issue_ok); end
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", io_overflow); end
      io_in_data = 16'h0009;
      tick();
      io_in_valid = 1'b0;
      n_checks++; if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", io_overflow); end
      n_checks++; if (io_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", io_count); end
      n_checks++; if (io_drops !== EXP_DROP1) begin n_fail++; $display("FAIL ovf_drops: got %h expected %h", io_drops, EXP_DROP1); end
      n_checks++; if (io_out_data !== 16'h0001) begin n_fail++; $display("FAIL ovf_head: got %h expected 0001", io_out_data); end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] exp_q [4];
      exp_q[0] = 16'h0002; exp_q[1] = 16'h0003; exp_q[2] = 16'h0004; exp_q[3] = 16'h000B;
      io_in_valid  = 1'b1;
      io_in_data   = 16'h000B;
      io_out_ready = 1'b1;
      tick();
      io_in_valid = 1'b0;
      n_checks++; if (io_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d expected 4", io_count); end
      n_checks++; if (io_drops !== EXP_DROP1) begin n_fail++; $display("FAIL fpp_drops: got %h expected %h", io_drops, EXP_DROP1); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (io_out_valid !== 1'b1 || io_out_data !== exp_q[i]) begin n_fail++; $display("FAIL fpp_data%0d: got v=%b d=%h expected v=1 d=%h", i, io_out_valid, io_out_data, exp_q[i]); end
         tick();
      end
      n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", io_out_valid); end
      n_checks++; if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_sticky: got %b expected 1", io_overflow); end
      io_out_ready = 1'b0;
   endtask

   task automatic test_issue();
      pulse_reset();
      io_issue = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++; if (io_issue_ok !== (i < 4)) begin n_fail++; $display("FAIL issue_ok_after%0d: got %b expected %b", i, io_issue_ok, (i < 4)); end
      end
      io_issue     = 1'b0;
      io_in_valid  = 1'b1;
      io_in_data   = 16'h0021;
      io_out_ready = 1'b1;
      tick();
      n_checks++; if (io_issue_ok !== 1'b0) begin n_fail++; $display("FAIL issue_ok_first_result: got %b expected 0", io_issue_ok); end
      io_in_data = 16'h0022;
      tick();
      n_checks++; if (io_issue_ok !== 1'b1) begin n_fail++; $display("FAIL issue_ok_after_pop: got %b expected 1", io_issue_ok); end
      n_checks++; if (io_out_data !== 16'h0022) begin n_fail++; $display("FAIL issue_head: got %h expected 0022", io_out_data); end
      io_in_valid = 1'b0;
      tick();
      io_out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      io_out_ready = 1'b1;
      io_in_valid  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         io_in_data = 16'(i);
         tick();
         n_checks++; if (io_out_valid !== 1'b1 || io_out_data !== 16'(i) || io_count !== 3'd1) begin n_fail++; $display("FAIL wrap%0d: got v=%b d=%h c=%0d expected v=1 d=%h c=1", i, io_out_valid, io_out_data, io_count, 16'(i)); end
      end
      io_in_valid = 1'b0;
      tick();
      n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b expected 0", io_out_valid); end
      io_out_ready = 1'b0;
   endtask

   task automatic test_drop_sat();
      pulse_reset();
      io_in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         io_in_data = 16'(16'h40 + i);
         tick();
      end
      for (int i = 1; i <= 300; i++) begin
         io_in_data = 16'h00FF;
         tick();
         if (i == 100) begin
            n_checks++; if (io_drops !== EXP_DROP100) begin n_fail++; $display("FAIL drops_100: got %h expected %h", io_drops, EXP_DROP100); end
         end
      end
      io_in_valid = 1'b0;
      n_checks++; if (io_drops !== EXP_DROPSAT) begin n_fail++; $display("FAIL drops_sat: got %h expected %h", io_drops, EXP_DROPSAT); end
      n_checks++; if (io_count !== 3'd4 || io_out_data !== 16'h0041) begin n_fail++; $display("FAIL drops_contents: got c=%0d d=%h expected c=4 d=0041", io_count, io_out_data); end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      io_in_valid = 1'b1;
      io_in_data  = 16'h0051;
      tick();
      io_in_data  = 16'h0052;
      tick();
      io_in_valid = 1'b0;
      io_issue    = 1'b1;
      tick();
      io_issue = 1'b0;
      n_checks++; if (io_count !== 3'd2 || io_issue_ok !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got c=%0d ok=%b expected c=2 ok=1", io_count, io_issue_ok); end
      io_issue = 1'b1;
      tick();
      io_issue = 1'b0;
      n_checks++; if (io_issue_ok !== 1'b0) begin n_fail++; $display("FAIL arst_pre_ok: got %b expected 0", io_issue_ok); end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (io_out_valid !== 1'b0 || io_count !== 3'd0) begin n_fail++; $display("FAIL arst_state: got v=%b c=%0d expected v=0 c=0", io_out_valid, io_count); end
      n_checks++; if (io_issue_ok !== 1'b1 || io_overflow !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got ok=%b ovf=%b expected ok=1 ovf=0", io_issue_ok, io_overflow); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_checks++; if (io_out_valid !== 1'b0 || io_issue_ok !== 1'b1) begin n_fail++; $display("FAIL arst_release: got v=%b ok=%b expected v=0 ok=1", io_out_valid, io_issue_ok); end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      #12;
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      test_order();
      test_overflow();
      test_full_push_pop();
      test_issue();
      test_wrap();
      test_drop_sat();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
